// File: rtl/tbird_pkg.sv
// Shared types and constants for the Thunderbird tail-light sequencer.
// Lamp vectors are ordered {Lc,Lb,La,Ra,Rb,Rc}; sequences light outward from La / Ra.
package tbird_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        L1   = 3'd1,
        L2   = 3'd2,
        L3   = 3'd3,
        R1   = 3'd4,
        R2   = 3'd5,
        R3   = 3'd6,
        HZ   = 3'd7
    } state_t;

    localparam logic [5:0] LAMPS_IDLE = 6'b000_000;
    localparam logic [5:0] LAMPS_L1   = 6'b001_000;
    localparam logic [5:0] LAMPS_L2   = 6'b011_000;
    localparam logic [5:0] LAMPS_L3   = 6'b111_000;
    localparam logic [5:0] LAMPS_R1   = 6'b000_100;
    localparam logic [5:0] LAMPS_R2   = 6'b000_110;
    localparam logic [5:0] LAMPS_R3   = 6'b000_111;
    localparam logic [5:0] LAMPS_HZ   = 6'b111_111;

    localparam logic [5:0] LEFT_MASK  = 6'b111_000;
    localparam logic [5:0] RIGHT_MASK = 6'b000_111;

    localparam logic [3:0] CODE_HZ    = 4'd10;
    localparam logic [3:0] CODE_NORM  = 4'd11;

    function automatic logic [5:0] state_lamps(input state_t s);
        logic [5:0] l;
        l = LAMPS_IDLE;
        case (s)
            L1:      l = LAMPS_L1;
            L2:      l = LAMPS_L2;
            L3:      l = LAMPS_L3;
            R1:      l = LAMPS_R1;
            R2:      l = LAMPS_R2;
            R3:      l = LAMPS_R3;
            HZ:      l = LAMPS_HZ;
            default: l = LAMPS_IDLE;
        endcase
        return l;
    endfunction

    function automatic logic [3:0] lamp_count(input logic [2:0] l);
        return 4'(l[0]) + 4'(l[1]) + 4'(l[2]);
    endfunction

endpackage

// File: rtl/tbird_tick_div.sv
// Free-running modulo-N counter; wrap is high for the single cycle the count sits at N-1.
module tbird_tick_div #(
    parameter int unsigned N = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic wrap
);

    localparam int unsigned W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] cnt_next;

    assign wrap     = (cnt_reg == LAST);
    assign cnt_next = wrap ? '0 : cnt_reg + W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/tbird_light_sequencer.sv
// Thunderbird tail-light sequencer: tick-stepped lamp FSM plus a 4-digit status scan.
// Optional brake override is compiled in with the TBIRD_BRAKE_EN macro.
module tbird_light_sequencer
    import tbird_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 25_000_000,
    parameter int unsigned SCAN_CYCLES = 50_000,
    parameter int unsigned NUM_DIGITS  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       left,
    input  logic       right,
    input  logic       haz,
    input  logic       brake,
    output logic [5:0] lamps,
    output logic [3:0] digit_code,
    output logic [3:0] digit_sel
);

    logic step_tick;
    logic scan_wrap;

    tbird_tick_div #(.N(STEP_CYCLES)) u_step_div (
        .clk   (clk),
        .rst_n (rst_n),
        .wrap  (step_tick)
    );

    tbird_tick_div #(.N(SCAN_CYCLES)) u_scan_div (
        .clk   (clk),
        .rst_n (rst_n),
        .wrap  (scan_wrap)
    );

    state_t     state_reg, state_next;
    logic [1:0] idx_reg, idx_next;
    logic [5:0] lamps_reg, lamps_next;
    logic [3:0] digit_sel_reg, digit_sel_next;
    logic [3:0] digit_code_reg, digit_code_next;
    logic       hz_req;

    assign hz_req = haz | (left & right);

    always_comb begin
        state_next = state_reg;
        if (step_tick) begin
            if (hz_req) begin
                state_next = (state_reg == HZ) ? IDLE : HZ;
            end else if (left) begin
                case (state_reg)
                    IDLE:    state_next = L1;
                    L1:      state_next = L2;
                    L2:      state_next = L3;
                    default: state_next = IDLE;
                endcase
            end else if (right) begin
                case (state_reg)
                    IDLE:    state_next = R1;
                    R1:      state_next = R2;
                    R2:      state_next = R3;
                    default: state_next = IDLE;
                endcase
            end else begin
                state_next = IDLE;
            end
        end
    end

`ifdef TBIRD_BRAKE_EN
    // Brake forces the side not in a turn sequence fully on; hazard blinking is left alone.
    always_comb begin
        lamps_next = state_lamps(state_next);
        if (brake) begin
            case (state_next)
                IDLE:           lamps_next = LAMPS_HZ;
                L1, L2, L3:     lamps_next = lamps_next | RIGHT_MASK;
                R1, R2, R3:     lamps_next = lamps_next | LEFT_MASK;
                default:        lamps_next = state_lamps(state_next);
            endcase
        end
    end
`else
    logic unused_brake;
    assign unused_brake = brake;

    always_comb begin
        lamps_next = state_lamps(state_next);
    end
`endif

    assign idx_next = scan_wrap ? idx_reg + 2'd1 : idx_reg;

    // Select and code are both derived from next-cycle values so the registered pair
    // always describes the same digit and the same lamp state shown on lamps.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
        assign digit_sel_next[gi] = (idx_next != 2'(gi));
    end

    always_comb begin
        digit_code_next = 4'd0;
        case (idx_next)
            2'd0:    digit_code_next = lamp_count(lamps_next[5:3]);
            2'd1:    digit_code_next = lamp_count(lamps_next[2:0]);
            2'd2:    digit_code_next = {1'b0, state_next};
            default: digit_code_next = (state_next == HZ) ? CODE_HZ : CODE_NORM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            idx_reg        <= 2'd0;
            lamps_reg      <= LAMPS_IDLE;
            digit_sel_reg  <= 4'b1110;
            digit_code_reg <= 4'd0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            lamps_reg      <= lamps_next;
            digit_sel_reg  <= digit_sel_next;
            digit_code_reg <= digit_code_next;
        end
    end

    assign lamps      = lamps_reg;
    assign digit_sel  = digit_sel_reg;
    assign digit_code = digit_code_reg;

endmodule

// File: tb/tb_tbird_light_sequencer.sv
// Self-checking bench for tbird_light_sequencer: directed steps then random requests,
// compared every cycle against a side/step-count model of the lamp behaviour.
module tb_tbird_light_sequencer;

    localparam int STEP = 4;
    localparam int SCAN = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       left = 1'b0;
    logic       right = 1'b0;
    logic       haz = 1'b0;
    logic       brake = 1'b0;
    logic [5:0] lamps;
    logic [3:0] digit_code;
    logic [3:0] digit_sel;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    // Model: kind 0=idle 1=left 2=right 3=hazard, n = lamps lit on the turning side.
    int m_kind  = 0;
    int m_n     = 0;
    int m_pcnt  = 0;
    int m_scnt  = 0;
    int m_idx   = 0;
    int m_brake = 0;

    tbird_light_sequencer #(
        .STEP_CYCLES (STEP),
        .SCAN_CYCLES (SCAN),
        .NUM_DIGITS  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .left       (left),
        .right      (right),
        .haz        (haz),
        .brake      (brake),
        .lamps      (lamps),
        .digit_code (digit_code),
        .digit_sel  (digit_sel)
    );

    always #5 clk = ~clk;

    function automatic int left_on();
        int nl;
        nl = (m_kind == 1) ? m_n : (m_kind == 3) ? 3 : 0;
`ifdef TBIRD_BRAKE_EN
        if (m_brake != 0 && (m_kind == 0 || m_kind == 2)) nl = 3;
`endif
        return nl;
    endfunction

    function automatic int right_on();
        int nr;
        nr = (m_kind == 2) ? m_n : (m_kind == 3) ? 3 : 0;
`ifdef TBIRD_BRAKE_EN
        if (m_brake != 0 && (m_kind == 0 || m_kind == 1)) nr = 3;
`endif
        return nr;
    endfunction

    function automatic logic [5:0] exp_lamps();
        int lf;
        int rf;
        lf = (1 << left_on()) - 1;
        rf = 7 & ~((1 << (3 - right_on())) - 1);
        return 6'((lf << 3) | rf);
    endfunction

    function automatic logic [3:0] exp_code();
        int s;
        s = (m_kind == 1) ? m_n : (m_kind == 2) ? 3 + m_n : (m_kind == 3) ? 7 : 0;
        case (m_idx)
            0:       return 4'(left_on());
            1:       return 4'(right_on());
            2:       return 4'(s);
            default: return (m_kind == 3) ? 4'd10 : 4'd11;
        endcase
    endfunction

    task automatic model_edge();
        logic tick;
        if (!rst_n) begin
            m_kind = 0; m_n = 0; m_pcnt = 0; m_scnt = 0; m_idx = 0; m_brake = 0;
        end else begin
            tick   = (m_pcnt == STEP - 1);
            m_pcnt = (m_pcnt + 1) % STEP;
            if (m_scnt == SCAN - 1) m_idx = (m_idx + 1) % 4;
            m_scnt  = (m_scnt + 1) % SCAN;
            m_brake = int'(brake);
            if (tick) begin
                if (haz || (left && right)) begin
                    m_kind = (m_kind == 3) ? 0 : 3;
                    m_n    = 0;
                end else if (left) begin
                    if (m_kind == 1 && m_n < 3) m_n = m_n + 1;
                    else if (m_kind == 0) begin m_kind = 1; m_n = 1; end
                    else begin m_kind = 0; m_n = 0; end
                end else if (right) begin
                    if (m_kind == 2 && m_n < 3) m_n = m_n + 1;
                    else if (m_kind == 0) begin m_kind = 2; m_n = 1; end
                    else begin m_kind = 0; m_n = 0; end
                end else begin
                    m_kind = 0; m_n = 0;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [5:0] el;
        logic [3:0] es;
        logic [3:0] ec;
        el = exp_lamps();
        es = 4'hF & ~(4'b0001 << m_idx);
        ec = exp_code();
        total++;
        assert (lamps === el) else begin
            bad++;
            $error("FAIL lamps cyc=%0d got=%b want=%b", cycle, lamps, el);
        end
        total++;
        assert (digit_sel === es) else begin
            bad++;
            $error("FAIL digit_sel cyc=%0d got=%b want=%b", cycle, digit_sel, es);
        end
        total++;
        assert (digit_code === ec) else begin
            bad++;
            $error("FAIL digit_code cyc=%0d got=%0d want=%0d", cycle, digit_code, ec);
        end
        $display("cyc=%0d rst_n=%b l=%b r=%b h=%b b=%b lamps=%b sel=%b code=%0d",
                 cycle, rst_n, left, right, haz, brake, lamps, digit_sel, digit_code);
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            cycle++;
            #1;
            check_outputs();
        end
    endtask

    initial begin
        // Reset for two cycles, then fixed reset values.
        rst_n = 1'b0;
        cyc(2);
        total++;
        assert (lamps === 6'b000000 && digit_sel === 4'b1110 && digit_code === 4'd0) else begin
            bad++;
            $error("FAIL reset_vals got=%b/%b/%0d want=000000/1110/0", lamps, digit_sel, digit_code);
        end

        // Left held from release: first tick lands on the 4th cycle.
        rst_n = 1'b1;
        left  = 1'b1;
        cyc(3);
        total++;
        assert (lamps === 6'b000000) else begin
            bad++;
            $error("FAIL pre_tick got=%b want=000000", lamps);
        end
        cyc(1);
        total++;
        assert (lamps === 6'b001000) else begin
            bad++;
            $error("FAIL left_l1 got=%b want=001000", lamps);
        end
        cyc(4);
        total++;
        assert (lamps === 6'b011000) else begin
            bad++;
            $error("FAIL left_l2 got=%b want=011000", lamps);
        end

        // Right added mid-L2: both requests act as hazard.
        cyc(2);
        right = 1'b1;
        cyc(2);
        total++;
        assert (lamps === 6'b111111) else begin
            bad++;
            $error("FAIL both_hz got=%b want=111111", lamps);
        end
        cyc(4);
        total++;
        assert (lamps === 6'b000000) else begin
            bad++;
            $error("FAIL hz_blink got=%b want=000000", lamps);
        end
        left  = 1'b0;
        right = 1'b0;
        cyc(4);

        // Short right pulse strictly between ticks is ignored.
        cyc(1);
        right = 1'b1;
        cyc(2);
        right = 1'b0;
        cyc(1);
        total++;
        assert (lamps === 6'b000000) else begin
            bad++;
            $error("FAIL short_pulse got=%b want=000000", lamps);
        end

        // Right sequence up to R1.
        right = 1'b1;
        cyc(4);
        total++;
        assert (lamps === 6'b000100) else begin
            bad++;
            $error("FAIL right_r1 got=%b want=000100", lamps);
        end
        right = 1'b0;
        brake = 1'b1;
        cyc(6);
        brake = 1'b0;
        haz   = 1'b1;
        cyc(6);

        // Reset mid-hazard aborts immediately.
        rst_n = 1'b0;
        cyc(1);
        total++;
        assert (lamps === 6'b000000) else begin
            bad++;
            $error("FAIL reset_mid_hz got=%b want=000000", lamps);
        end
        rst_n = 1'b1;
        haz   = 1'b0;
        cyc(2);

        // Random request traffic with occasional brake and reset.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                left  = ($urandom_range(0, 2) != 0);
                right = ($urandom_range(0, 2) == 0);
                haz   = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 9) == 0) brake = ~brake;
            rst_n = ($urandom_range(0, 199) != 0);
            cyc(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
